// File: rtl/calc_pkg.sv
// Shared definitions for the calc_arbiter slice.
//   - op codes for the four-operation calculator
//   - FSM state encoding of the arbiter
//   - result substituted for a divide by zero
package calc_pkg;

  typedef enum logic [1:0] {
    SUM = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DIVZERO_RESULT = 32'hFFFF_FFFF;

  // MUL and DIV are the long operations (op[1] set); they get extra EXEC cycles.
  function automatic logic is_muldiv(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/calc_arbiter_if.sv
// Bus between the two clients and calc_arbiter.
//   req0_*/req1_*   : request channels (valid, ready, op, val1, val2)
//   resp0_*/resp1_* : response channels (valid, ready); resp_data and
//                     resp_divzero are shared by both response ports
//   busy            : arbiter FSM not idle
//   dbg_state       : current arbiter FSM state, for observation only
//
// Handshake rule for every channel: a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge. A source that raises
// valid keeps it (and its payload) until that transfer; ready may depend
// combinationally on valid, valid never depends on ready.
interface calc_arbiter_if;
  import calc_pkg::*;

  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_val1;
  logic [31:0] req0_val2;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_val1;
  logic [31:0] req1_val2;

  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp_data;
  logic        resp_divzero;

  logic        busy;
  state_t      dbg_state;

  modport slave (
    input  req0_valid, req0_op, req0_val1, req0_val2,
    input  req1_valid, req1_op, req1_val1, req1_val2,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data, resp_divzero,
    output busy, dbg_state
  );

  modport master (
    output req0_valid, req0_op, req0_val1, req0_val2,
    output req1_valid, req1_op, req1_val1, req1_val2,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data, resp_divzero,
    input  busy, dbg_state
  );

endinterface

// File: rtl/combinational_calculator.sv
// Purely combinational 32-bit unsigned calculator.
//   op          : SUM/SUB/MUL/DIV
//   val1, val2  : operands A and B
//   result      : A op B truncated to 32 bits; DIVZERO_RESULT for A/0
//   div_by_zero : high when op is DIV and B is zero
module combinational_calculator
  import calc_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  output logic [31:0] result,
  output logic        div_by_zero
);

  always_comb begin
    result      = '0;
    div_by_zero = (op == DIV) && (val2 == '0);
    case (op)
      SUM:     result = val1 + val2;
      SUB:     result = val1 - val2;
      MUL:     result = val1 * val2;
      DIV:     result = div_by_zero ? DIVZERO_RESULT : (val1 / val2);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one calculator between two requesters.
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   bus      : request/response channels, busy and FSM state (calc_arbiter_if)
// Parameter MULDIV_WAIT (0..15): extra EXEC cycles for MUL/DIV so the
// calculator can be constrained as a multicycle path.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int MULDIV_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  calc_arbiter_if.slave bus
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        owner;
  logic [1:0]  op_q;
  logic [31:0] val1_q, val2_q;
  logic [3:0]  wait_cnt;
  logic [31:0] resp_data_q;
  logic        divzero_q;

  logic        any_valid;
  logic        grant;
  logic        accept;
  logic        resp_take;
  logic [1:0]  sel_op;
  logic [31:0] sel_val1, sel_val2;
  logic [31:0] calc_result;
  logic        calc_divzero;

  // Single requester wins outright; with both valid the one that did not
  // win last time gets the slot.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign accept    = !rst && (state == IDLE) && any_valid;
  assign resp_take = (state == RESP) && (owner ? bus.resp1_ready : bus.resp0_ready);

  assign sel_op   = grant ? bus.req1_op   : bus.req0_op;
  assign sel_val1 = grant ? bus.req1_val1 : bus.req0_val1;
  assign sel_val2 = grant ? bus.req1_val2 : bus.req0_val2;

  combinational_calculator u_calc (
    .op          (op_q),
    .val1        (val1_q),
    .val2        (val2_q),
    .result      (calc_result),
    .div_by_zero (calc_divzero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op_q        <= SUM;
      val1_q      <= '0;
      val2_q      <= '0;
      wait_cnt    <= '0;
      resp_data_q <= '0;
      divzero_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        owner      <= grant;
        op_q       <= sel_op;
        val1_q     <= sel_val1;
        val2_q     <= sel_val2;
        wait_cnt   <= is_muldiv(sel_op) ? 4'(MULDIV_WAIT) : 4'd0;
      end else if (state == EXEC) begin
        if (wait_cnt != 4'd0) begin
          wait_cnt <= wait_cnt - 4'd1;
        end else begin
          resp_data_q <= calc_result;
          divzero_q   <= calc_divzero;
        end
      end
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt       = state;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        if (wait_cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        bus.resp0_valid = !owner;
        bus.resp1_valid = owner;
        if (resp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.resp_data    = resp_data_q;
  assign bus.resp_divzero = divzero_q;
  assign bus.busy         = (state != IDLE);
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_calc_arbiter.sv
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int MW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_arbiter_if bus();

  calc_arbiter #(.MULDIV_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];   // {port, data}

  typedef struct {
    bit          port;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          exp_dz;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit port, input bit v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_val1 = a; bus.req1_val2 = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_val1 = a; bus.req0_val2 = b;
    end
  endtask

  // Raise valid at a falling edge, wait for ready, drop valid one cycle later.
  // t_acc is the cycle in which the accept handshake took place.
  task automatic issue(input bit port, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = -1;
    @(negedge clk);
    drive_req(port, 1'b1, op, a, b);
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (port ? bus.req1_ready : bus.req0_ready) begin
        got   = 1'b1;
        t_acc = cyc;
      end
    end
    chk("accept_seen", 32'(got), 32'd1);
    @(negedge clk);
    drive_req(port, 1'b0, op, a, b);
  endtask

  // Wait for the response on 'port' and check timing and payload.
  // Returns in the response cycle, 1 ns after the falling edge.
  task automatic wait_resp(input bit port, input int t_acc, input int lat,
                           input logic [31:0] exp, input bit dz, input string name);
    bit got;
    int t_resp;
    got    = 1'b0;
    t_resp = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (port ? bus.resp1_valid : bus.resp0_valid) begin
        got    = 1'b1;
        t_resp = cyc;
      end
    end
    chk({name, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, "_latency"}, 32'(t_resp - t_acc), 32'(lat));
      chk({name, "_data"}, bus.resp_data, exp);
      chk({name, "_divzero"}, 32'(bus.resp_divzero), 32'(dz));
      chk({name, "_other_valid"}, 32'(port ? bus.resp0_valid : bus.resp1_valid), 32'd0);
      chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    end
  endtask

  // Contention stream: requester 0 op k is SUM (1000k+7)+(k+3),
  // requester 1 op k is SUB (50k)-(k+1). Valid drops after four ops.
  task automatic set_cont(input bit port, input int k);
    if (k >= 4) begin
      drive_req(port, 1'b0, SUM, 32'd0, 32'd0);
    end else if (port) begin
      drive_req(1'b1, 1'b1, SUB, 32'(50 * k), 32'(k + 1));
    end else begin
      drive_req(1'b0, 1'b1, SUM, 32'(1000 * k + 7), 32'(k + 3));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int t_acc, t_acc1;
    int n0, n1, last_hs, seen;
    bit exp_gnt, g, upd, upd_port;
    logic [32:0] e;

    vecs[0] = '{1'b0, SUM, 32'd5,          32'd7,        32'd12,         1'b0, 2};
    vecs[1] = '{1'b1, SUB, 32'd0,          32'd1,        32'hFFFF_FFFF,  1'b0, 2};
    vecs[2] = '{1'b1, MUL, 32'h0001_0000,  32'h0001_0000, 32'd0,         1'b0, 2 + MW};
    vecs[3] = '{1'b0, DIV, 32'd100,        32'd0,        32'hFFFF_FFFF,  1'b1, 2 + MW};
    vecs[4] = '{1'b0, DIV, 32'd100,        32'd7,        32'd14,         1'b0, 2 + MW};
    vecs[5] = '{1'b1, SUM, 32'hFFFF_FFFF,  32'd2,        32'd1,          1'b0, 2};
    vecs[6] = '{1'b0, MUL, 32'h1234_5678,  32'h10,       32'h2345_6780,  1'b0, 2 + MW};
    vecs[7] = '{1'b1, DIV, 32'd7,          32'd100,      32'd0,          1'b0, 2 + MW};

    drive_req(1'b0, 1'b0, SUM, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, SUM, 32'd0, 32'd0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;

    // Reset state, with both requests valid: no ready while rst is high.
    @(negedge clk);
    drive_req(1'b0, 1'b1, SUM, 32'd1, 32'd1);
    drive_req(1'b1, 1'b1, SUM, 32'd1, 32'd1);
    #1;
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(bus.resp1_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_divzero", 32'(bus.resp_divzero), 32'd0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, SUM, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, SUM, 32'd0, 32'd0);
    rst = 1'b0;

    // Table-driven single operations.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, t_acc);
      wait_resp(vecs[i].port, t_acc, vecs[i].lat, vecs[i].exp, vecs[i].exp_dz,
                $sformatf("vec%0d", i));
    end

    // Contention: both valid, round-robin alternation, accept right after
    // each response handshake. Last table op came from requester 1.
    n0 = 0; n1 = 0; last_hs = -1; upd = 1'b0; upd_port = 1'b0;
    exp_gnt = ~vecs[7].port;
    @(negedge clk);
    set_cont(1'b0, 0);
    set_cont(1'b1, 0);
    for (int i = 0; i < 200 && (n0 < 4 || n1 < 4 || exp_q.size() > 0); i++) begin
      if (upd) begin
        set_cont(upd_port, upd_port ? n1 : n0);
        upd = 1'b0;
      end
      #1;
      if (bus.resp0_valid || bus.resp1_valid) begin
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          chk("cont_spurious_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cont_resp_port", 32'(bus.resp1_valid), 32'(e[32]));
          chk("cont_resp_data", bus.resp_data, e[31:0]);
        end
      end
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        chk("cont_both_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        chk("cont_grant", 32'(g), 32'(exp_gnt));
        exp_gnt = ~exp_gnt;
        if (last_hs >= 0) chk("cont_gap", 32'(cyc - last_hs), 32'd1);
        if (g) begin
          exp_q.push_back({1'b1, 32'(50 * n1) - 32'(n1 + 1)});
          n1++;
        end else begin
          exp_q.push_back({1'b0, 32'(1000 * n0 + 7) + 32'(n0 + 3)});
          n0++;
        end
        upd      = 1'b1;
        upd_port = g;
      end
      @(negedge clk);
    end
    chk("cont_done_req0", 32'(n0), 32'd4);
    chk("cont_done_req1", 32'(n1), 32'd4);
    chk("cont_queue_empty", 32'(exp_q.size()), 32'd0);
    drive_req(1'b0, 1'b0, SUM, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, SUM, 32'd0, 32'd0);

    // Backpressure on requester 0 while requester 1 waits.
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    issue(1'b0, SUM, 32'd1, 32'd2, t_acc);
    drive_req(1'b1, 1'b1, SUM, 32'd4, 32'd5);
    wait_resp(1'b0, t_acc, 2, 32'd3, 1'b0, "bp_r0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) bus.resp1_ready = 1'b1;
      #1;
      chk("bp_hold_valid", 32'(bus.resp0_valid), 32'd1);
      chk("bp_hold_data", bus.resp_data, 32'd3);
      chk("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_resp1_valid", 32'(bus.resp1_valid), 32'd0);
    end
    @(negedge clk);
    bus.resp0_ready = 1'b1;
    #1;
    chk("bp_hs_valid", 32'(bus.resp0_valid), 32'd1);
    chk("bp_hs_no_accept", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_next_accept", 32'(bus.req1_ready), 32'd1);
    chk("bp_resp0_dropped", 32'(bus.resp0_valid), 32'd0);
    t_acc1 = cyc;
    @(negedge clk);
    drive_req(1'b1, 1'b0, SUM, 32'd0, 32'd0);
    wait_resp(1'b1, t_acc1, 2, 32'd9, 1'b0, "bp_r1");

    // Reset in the middle of a MUL.
    issue(1'b0, MUL, 32'd6, 32'd7, t_acc);
    rst = 1'b1;
    drive_req(1'b1, 1'b1, SUM, 32'd3, 32'd3);
    #1;
    chk("midrst_state_exec", 32'(bus.dbg_state), 32'(EXEC));
    chk("midrst_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b1, 1'b0, SUM, 32'd0, 32'd0);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("midrst_resp_data", bus.resp_data, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (bus.resp0_valid || bus.resp1_valid) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);

    // After reset requester 0 wins a tie.
    @(negedge clk);
    drive_req(1'b0, 1'b1, SUM, 32'd2, 32'd2);
    drive_req(1'b1, 1'b1, SUM, 32'd3, 32'd3);
    #1;
    chk("postrst_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("postrst_req1_ready", 32'(bus.req1_ready), 32'd0);
    t_acc = cyc;
    @(negedge clk);
    drive_req(1'b0, 1'b0, SUM, 32'd0, 32'd0);
    wait_resp(1'b0, t_acc, 2, 32'd4, 1'b0, "postrst_r0");
    issue(1'b1, SUM, 32'd3, 32'd3, t_acc);
    wait_resp(1'b1, t_acc, 2, 32'd6, 1'b0, "postrst_r1");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Shares one 32-bit four-operation calculator (SUM/SUB/MUL/DIV) between two requesters.
- Uses round-robin arbitration and valid/ready handshakes.
- Registers operands, waits extra cycles for MUL/DIV so they can be constrained as multicycle paths, and registers the result.
- Substitutes a defined value for divide-by-zero.
- Sits between the two client blocks and the shared calculator datapath.

Parameters:
- MULDIV_WAIT, 2, extra EXEC cycles for MUL/DIV (0..15); SUM/SUB take none.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  2  operation code
- req0_val1  in  32  operand A
- req0_val2  in  32  operand B
- req1_valid, req1_ready, req1_op, req1_val1, req1_val2: same as requester 0, for requester 1
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 takes result
- resp1_valid  out  1  result for requester 1 available
- resp1_ready  in  1  requester 1 takes result
- resp_data  out  32  result, shared by both response ports
- resp_divzero  out  1  result came from DIV with val2 == 0
- busy  out  1  FSM not in IDLE

Behaviour:
- Single clock domain: clk. Reset rst is synchronous, active-high.
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins first), wait counter = 0.
  - resp_data = 0, resp_divzero = 0, resp0/1_valid = 0, busy = 0.
  - req0/1_ready forced to 0 during any cycle with rst high.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req_ready is combinational: high only for the granted requester and only in IDLE.
  - Grant if only one requester is valid: that one. If both are valid: the one not equal to last_grant.
  - On accept: latch op/val1/val2, set last_grant and owner, load wait counter (MULDIV_WAIT for MUL/DIV, 0 otherwise). Next state is EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - The calculator sees the registered operands.
  - Counter nonzero: decrement and stay.
  - Counter zero: capture the result into resp_data and go to RESP.
  - DIV with val2 == 0: capture 32'hFFFF_FFFF and set resp_divzero = 1. Otherwise resp_divzero = 0.
- RESP:
  - resp_valid is high only on the owner's port, and resp_data/resp_divzero are held stable.
  - Stay in RESP until the owner's resp_ready is high; then go to IDLE.
  - The other port's resp_ready is ignored.
- Latency: accept in cycle T; resp_valid rises in T+2 (SUM/SUB) or T+2+MULDIV_WAIT (MUL/DIV).
- Throughput: response handshake in cycle R; the next accept is possible at R+1 (no accept in R).
- Arithmetic: 32-bit unsigned, results truncated mod 2^32 (SUM/SUB wrap; MUL keeps the low 32 bits; DIV is unsigned, truncating).
- Request fields may change while not accepted; only the accept-cycle values matter.
- Simultaneous valid on both ports while busy: neither gets ready; both must hold until granted. There is no starvation because round-robin alternates.
- Reset in EXEC or RESP: the outstanding operation is dropped with no response, and all outputs return to reset values the next cycle.

Decomposition:
- Shared package calc_pkg holds:
  - op codes SUM=2'd0, SUB=2'd1, MUL=2'd2, DIV=2'd3;
  - state encodings IDLE/EXEC/RESP;
  - DIVZERO_RESULT = 32'hFFFF_FFFF.
- One sub-module: the existing combinational_calculator, instantiated once on the registered operands. Arbitration, FSM and counter stay in calc_arbiter.

Test Plan:
- Reset then single request: req0 SUM 5+7 accepted at T -> resp0_valid at T+2, resp_data = 12, divzero = 0, resp1_valid = 0.
- Wrap and MUL timing with MULDIV_WAIT=2: req1 SUB 0-1 -> 32'hFFFF_FFFF at T+2; req1 MUL 32'h10000 * 32'h10000 -> 0 at T+4.
- Divide by zero: req0 DIV 100/0 -> resp_data = 32'hFFFF_FFFF, resp_divzero = 1. Then req0 DIV 100/7 -> 14, divzero = 0.
- Contention: both valid every cycle, 4 ops each, resp_ready always 1 -> grants alternate 0,1,0,1…; each accept exactly one cycle after the previous response handshake.
- Backpressure: resp0_ready low for 5 cycles -> resp0_valid and resp_data held stable, req1_ready stays 0, busy = 1. Raising resp1_ready has no effect.
- Reset mid-EXEC of a MUL -> next cycle busy = 0, no resp_valid ever appears for that op, and a fresh req1 is accepted first after reset only if req0 is idle.
